// File: rtl/fp_int_to_fp_if.sv
`default_nettype none
// ============================================================================
// Module  : fp_int_to_fp_if
// Brief   : Request/result bundle for the integer-to-binary32 converter.
// Revision: 1.0
// ============================================================================
interface fp_int_to_fp_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_start;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_signed;
   logic [2:0]            in_rm;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_busy;
   logic                  out_flag_NX;

   modport master (
      output in_start, in_data, in_signed, in_rm,
      input  out_data, out_valid, out_busy, out_flag_NX
   );

   modport slave (
      input  in_start, in_data, in_signed, in_rm,
      output out_data, out_valid, out_busy, out_flag_NX
   );
endinterface
`default_nettype wire

// File: rtl/fp_int_to_fp.sv
`default_nettype none
// ============================================================================
// Module  : fp_int_to_fp
// Brief   : Iterative FCVT.S.W / FCVT.S.WU with RISC-V rounding and NX flag.
// Revision: 1.0
// ============================================================================
module fp_int_to_fp #(
   parameter int DATA_WIDTH = 32
) (
   input  wire logic        in_clk,
   input  wire logic        in_rst,
   fp_int_to_fp_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_NORM  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [7:0] c_EXP_INIT = 8'd158;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_mag;
   logic [7:0]  r_exp;
   logic        r_sign;
   logic [2:0]  r_rm;
   logic [31:0] r_out_data;
   logic        r_out_nx;

   logic        w_cap_sign;
   logic [31:0] w_cap_mag;
   logic        w_cap_zero;
   logic [22:0] w_m;
   logic        w_g;
   logic        w_st;
   logic        w_lsb;
   logic        w_inc;
   logic [23:0] w_sum;
   logic [22:0] w_man_rnd;
   logic [7:0]  w_exp_rnd;

   // -2^31 negates to itself, which is exactly the unsigned magnitude wanted.
   assign w_cap_sign = bus.in_signed & bus.in_data[31];
   assign w_cap_mag  = w_cap_sign ? (~bus.in_data + 32'd1) : bus.in_data;
   assign w_cap_zero = (w_cap_mag == 32'd0);

   assign w_m   = r_mag[30:8];
   assign w_g   = r_mag[7];
   assign w_st  = |r_mag[6:0];
   assign w_lsb = r_mag[8];

   always_comb begin
      w_inc = 1'b0;
      case (r_rm)
         3'b001:  w_inc = 1'b0;
         3'b010:  w_inc = r_sign & (w_g | w_st);
         3'b011:  w_inc = ~r_sign & (w_g | w_st);
         3'b100:  w_inc = w_g;
         default: w_inc = w_g & (w_st | w_lsb);
      endcase
   end

   // Carry out of the mantissa bumps the exponent; E tops out at 159, no overflow.
   assign w_sum     = {1'b0, w_m} + {23'd0, w_inc};
   assign w_man_rnd = w_sum[23] ? 23'd0 : w_sum[22:0];
   assign w_exp_rnd = r_exp + {7'd0, w_sum[23]};

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_start) w_next = w_cap_zero ? S_DONE : S_NORM;
         S_NORM:  if (r_mag[31]) w_next = S_ROUND;
         S_ROUND: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_mag      <= 32'd0;
         r_exp      <= 8'd0;
         r_sign     <= 1'b0;
         r_rm       <= 3'd0;
         r_out_data <= 32'd0;
         r_out_nx   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_start) begin
                  r_sign <= w_cap_sign;
                  r_mag  <= w_cap_mag;
                  r_rm   <= bus.in_rm;
                  r_exp  <= c_EXP_INIT;
                  if (w_cap_zero) begin
                     r_out_data <= 32'd0;
                     r_out_nx   <= 1'b0;
                  end
               end
            end
            S_NORM: begin
               if (!r_mag[31]) begin
                  r_mag <= {r_mag[30:0], 1'b0};
                  r_exp <= r_exp - 8'd1;
               end
            end
            S_ROUND: begin
               r_out_data <= {r_sign, w_exp_rnd, w_man_rnd};
               r_out_nx   <= w_g | w_st;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_data    = r_out_data;
   assign bus.out_flag_NX = r_out_nx;
   assign bus.out_valid   = (r_state == S_DONE);
   assign bus.out_busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fp_int_to_fp.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_int_to_fp
// Brief   : Scoreboard bench for fp_int_to_fp with an independent rounding model.
// Revision: 1.0
// ============================================================================
module tb_fp_int_to_fp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b1;

   typedef struct {
      logic [31:0] din;
      logic [31:0] res;
      logic        nx;
      int          vcyc;
   } exp_t;

   exp_t sb[$];

   fp_int_to_fp_if bus ();

   fp_int_to_fp dut (
      .in_clk (clk),
      .in_rst (rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference by exact remainder/half-ULP comparison rather than guard/sticky bits.
   function automatic void ref_conv(input logic [31:0] d, input logic sgn, input logic [2:0] rm,
                                    output logic [31:0] res, output logic nx, output int voff);
      logic s;
      logic inc;
      logic [7:0] e;
      longint unsigned mag, kept, rem, half;
      int p, sh;
      s   = sgn & d[31];
      mag = s ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
      res = 32'd0;
      nx  = 1'b0;
      voff = 0;
      if (mag != 0) begin
         p = 0;
         for (int i = 0; i < 32; i++) if (mag[i]) p = i;
         voff = 33 - p;
         inc = 1'b0;
         if (p <= 23) begin
            kept = mag << (23 - p);
         end else begin
            sh   = p - 23;
            kept = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            nx   = (rem != 0);
            case (rm)
               3'd1:    inc = 1'b0;
               3'd2:    inc = s & nx;
               3'd3:    inc = ~s & nx;
               3'd4:    inc = (rem >= half);
               default: inc = (rem > half) || ((rem == half) && kept[0]);
            endcase
         end
         kept = kept + {63'd0, inc};
         e = 8'(127 + p);
         if (kept[24]) begin
            kept = kept >> 1;
            e = e + 8'd1;
         end
         res = {s, e, kept[22:0]};
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !rst && bus.out_valid) begin
         if (sb.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_valid at cyc %0d data %08h", cyc, bus.out_data);
         end else begin
            e = sb.pop_front();
            checks = checks + 3;
            if (bus.out_data !== e.res) begin
               errors = errors + 1;
               $display("FAIL data in=%08h got %08h want %08h", e.din, bus.out_data, e.res);
            end
            if (bus.out_flag_NX !== e.nx) begin
               errors = errors + 1;
               $display("FAIL nx in=%08h got %0b want %0b", e.din, bus.out_flag_NX, e.nx);
            end
            if (cyc !== e.vcyc) begin
               errors = errors + 1;
               $display("FAIL latency in=%08h got cyc %0d want cyc %0d", e.din, cyc, e.vcyc);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.out_busy === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL idle_timeout busy got 1 want 0");
      end
   endtask

   task automatic issue_k(input logic [31:0] d, input logic s, input logic [2:0] rm,
                          input logic [31:0] res, input logic nx, input int voff);
      exp_t e;
      wait_idle();
      e.din  = d;
      e.res  = res;
      e.nx   = nx;
      e.vcyc = cyc + 1 + voff;
      sb.push_back(e);
      bus.in_data   = d;
      bus.in_signed = s;
      bus.in_rm     = rm;
      bus.in_start  = 1'b1;
      @(negedge clk);
      bus.in_start  = 1'b0;
      bus.in_data   = $urandom;
      bus.in_signed = 1'($urandom);
      bus.in_rm     = 3'($urandom);
   endtask

   task automatic issue(input logic [31:0] d, input logic s, input logic [2:0] rm);
      logic [31:0] res;
      logic nx;
      int voff;
      ref_conv(d, s, rm, res, nx, voff);
      issue_k(d, s, rm, res, nx, voff);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.out_busy === 1'b1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL drain_timeout pending got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      bus.in_start = 1'b0; bus.in_data = 32'd0; bus.in_signed = 1'b0; bus.in_rm = 3'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks = checks + 1;
      if ({bus.out_data, bus.out_valid, bus.out_busy, bus.out_flag_NX} !== 35'd0) begin
         errors = errors + 1;
         $display("FAIL reset_outputs got %09h want 0", {bus.out_data, bus.out_valid, bus.out_busy, bus.out_flag_NX});
      end
      rst = 1'b0;
      @(negedge clk);
      checks = checks + 1;
      if (bus.out_busy !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_busy got %0b want 0", bus.out_busy);
      end
   endtask

   task automatic test_directed();
      issue_k(32'h0000_0001, 1'b1, 3'd0, 32'h3F80_0000, 1'b0, 33);
      issue_k(32'hFFFF_FFFF, 1'b1, 3'd0, 32'hBF80_0000, 1'b0, 33);
      issue_k(32'h8000_0000, 1'b1, 3'd0, 32'hCF00_0000, 1'b0, 2);
      issue_k(32'hFFFF_FFFF, 1'b0, 3'd0, 32'h4F80_0000, 1'b1, 2);
      issue_k(32'hFFFF_FFFF, 1'b0, 3'd1, 32'h4F7F_FFFF, 1'b1, 2);
      issue_k(32'h0100_0001, 1'b1, 3'd0, 32'h4B80_0000, 1'b1, 9);
      issue_k(32'h0100_0001, 1'b1, 3'd3, 32'h4B80_0001, 1'b1, 9);
      issue_k(32'h0100_0001, 1'b1, 3'd2, 32'h4B80_0000, 1'b1, 9);
      issue_k(32'h0100_0001, 1'b1, 3'd4, 32'h4B80_0001, 1'b1, 9);
      issue_k(32'h0100_0003, 1'b1, 3'd7, 32'h4B80_0002, 1'b1, 9);
      issue_k(32'hFEFF_FFFF, 1'b1, 3'd2, 32'hCB80_0001, 1'b1, 9);
      drain();
   endtask

   task automatic test_zero();
      for (int r = 0; r < 8; r++) issue_k(32'd0, r[0], 3'(r), 32'd0, 1'b0, 0);
      drain();
   endtask

   task automatic test_random();
      for (int k = 0; k < 32; k++) issue($urandom >> k, 1'($urandom), 3'($urandom));
      for (int k = 0; k < 24; k++) issue($urandom, 1'($urandom), 3'($urandom_range(0, 4)));
      drain();
   endtask

   task automatic test_back_to_back();
      int n = 0;
      issue(32'h8765_4321, 1'b0, 3'd3);
      while (bus.out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks = checks + 1;
      if (bus.out_busy !== 1'b0 || n >= 100) begin
         errors = errors + 1;
         $display("FAIL b2b_idle busy got %0b want 0 (wait %0d)", bus.out_busy, n);
      end
      issue(32'hC000_0001, 1'b1, 3'd2);
      issue(32'h00FF_FFFF, 1'b0, 3'd4);
      drain();
   endtask

   task automatic test_start_held();
      int nval = 0;
      int nbad = 0;
      wait_idle();
      mon_en = 1'b0;
      bus.in_data = 32'h8000_0000; bus.in_signed = 1'b1; bus.in_rm = 3'd0; bus.in_start = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            nval++;
            if (bus.out_data !== 32'hCF00_0000) nbad++;
         end
         if (k == 0) begin
            checks = checks + 1;
            if (bus.out_busy !== 1'b1) begin
               errors = errors + 1;
               $display("FAIL held_busy got %0b want 1", bus.out_busy);
            end
         end
      end
      bus.in_start = 1'b0;
      checks = checks + 1;
      if (bus.out_busy !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL held_idle_gap busy got %0b want 0", bus.out_busy);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) nval++;
      end
      checks = checks + 2;
      if (nval !== 5) begin
         errors = errors + 1;
         $display("FAIL held_valid_count got %0d want 5", nval);
      end
      if (nbad !== 0) begin
         errors = errors + 1;
         $display("FAIL held_data bad results got %0d want 0", nbad);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int nval = 0;
      issue(32'h1234_5678, 1'b0, 3'd0);
      drain();
      mon_en = 1'b0;
      bus.in_data = 32'h0000_0001; bus.in_signed = 1'b1; bus.in_rm = 3'd0; bus.in_start = 1'b1;
      @(negedge clk);
      bus.in_start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks = checks + 1;
      if ({bus.out_data, bus.out_valid, bus.out_busy, bus.out_flag_NX} !== 35'd0) begin
         errors = errors + 1;
         $display("FAIL midreset_outputs got %09h want 0", {bus.out_data, bus.out_valid, bus.out_busy, bus.out_flag_NX});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) nval++;
      end
      checks = checks + 1;
      if (nval !== 0) begin
         errors = errors + 1;
         $display("FAIL midreset_valid got %0d want 0", nval);
      end
      mon_en = 1'b1;
      issue_k(32'h0000_0001, 1'b1, 3'd0, 32'h3F80_0000, 1'b0, 33);
      drain();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_zero();
      test_random();
      test_back_to_back();
      test_start_held();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fp_int_to_fp.md
# fp_int_to_fp

Sequential integer-to-single-precision converter for the FP unit, implementing FCVT.S.W (signed) and FCVT.S.WU (unsigned). It is the inverse-direction partner of the FP compare path: the compare path consumes FP operands and returns an integer result, while this block consumes a 32-bit integer and returns an IEEE-754 binary32 value. Normalisation is iterative, one bit per cycle, and rounding follows the RISC-V rounding modes. It raises the NX (inexact) flag for the FP status logic.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  reset; asynchronous, active-high.
- in_start  input  1  request; sampled only in IDLE.
- in_data  input  32  integer operand.
- in_signed  input  1  1 = two's-complement operand (FCVT.S.W), 0 = unsigned (FCVT.S.WU).
- in_rm  input  3  rounding mode. 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 are treated as RNE.
- out_data  output  32  binary32 result; held until the next result is written.
- out_valid  output  1  one-cycle pulse; out_data and out_flag_NX are valid while it is high.
- out_busy  output  1  high whenever state != IDLE.
- out_flag_NX  output  1  inexact flag, written together with out_data.

## Operation
- States: IDLE, NORM, ROUND, DONE.
- **IDLE, in_start=1 (capture):**
  - Latch sign = in_signed & in_data[31].
  - Latch mag = sign ? -in_data : in_data, as a 32-bit unsigned value. -2^31 gives 0x80000000.
  - Latch rm and E = 158 (127+31), 8-bit.
  - If mag == 0: write out_data = 0x00000000 and NX = 0, then go to DONE. The result is +0 for every rm.
  - Otherwise go to NORM.
- **NORM:**
  - If mag[31] == 0: mag <<= 1, E -= 1, stay in NORM.
  - If mag[31] == 1: go to ROUND.
  - At most 31 shift cycles.
- **ROUND:**
  - Fields: m = mag[30:8] (23 bits), g = mag[7], st = |mag[6:0], lsb = mag[8].
  - Increment inc by mode:
    - RNE: g & (st | lsb).
    - RTZ: 0.
    - RDN: sign & (g | st).
    - RUP: !sign & (g | st).
    - RMM: g.
  - m + inc is computed 24 bits wide. On carry out, m = 0 and E += 1.
  - Maximum E is 159, so overflow to infinity cannot occur.
  - Write out_data = {sign, E, m} and out_flag_NX = g | st, then go to DONE.
- **DONE:** out_valid = 1 for this cycle only, then go to IDLE.
- in_start is ignored while out_busy = 1, including in DONE. No queueing.
- in_data, in_signed and in_rm are not required to be held after the capture edge.

## Timing
- **Reset (asynchronous assert):**
  - state = IDLE.
  - out_data = 0x00000000, out_valid = 0, out_busy = 0, out_flag_NX = 0.
  - Internal mag, E, sign and rm are cleared.
- **Reset mid-operation:** the conversion is aborted, no out_valid pulse is produced, and out_data reads 0.
- **Latency:** with capture edge = edge 0 and s = leading-zero count of mag:
  - Nonzero operand: out_valid is high in the cycle after edge s+2, i.e. a latency of s+2 cycles.
  - Range is 2 cycles (s = 0) to 33 cycles (s = 31).
  - Zero operand: out_valid is high in the cycle after edge 0, i.e. a latency of 1 cycle.
- **Busy window:** out_busy rises after edge 0 and falls after the edge that leaves DONE.
  - The earliest next accepted start is the edge that ends the out_valid cycle plus one, i.e. the first IDLE cycle.
- out_data and out_flag_NX change only at the ROUND→DONE edge, the zero-capture edge, or reset.

## Test plan
- **Signed 1, RNE:** in_data=0x00000001, in_signed=1, rm=000 -> out_data=0x3F800000, NX=0, out_valid 33 cycles after capture.
- **Signed negatives:**
  - in_data=0xFFFFFFFF, signed -> 0xBF800000, NX=0.
  - in_data=0x80000000, signed -> 0xCF000000, NX=0, latency 2.
- **Unsigned max:** in_data=0xFFFFFFFF, in_signed=0:
  - rm=RNE -> 0x4F800000, NX=1 (mantissa carry, E=159).
  - rm=RTZ -> 0x4F7FFFFF, NX=1.
- **Tie, in_data=0x01000001, signed:**
  - RNE -> 0x4B800000, NX=1.
  - RUP -> 0x4B800001.
  - RDN -> 0x4B800000.
  - RMM -> 0x4B800001.
- **Zero:** in_data=0, each rm -> out_data=0x00000000, NX=0, latency 1.
  - Also: in_start held high through the operation -> exactly one out_valid per accepted start, and starts during busy are ignored.
- **Reset mid-operation:** assert in_rst during NORM of in_data=0x00000001 -> all outputs 0 immediately and no out_valid.
  - A new start after release converts normally.
